// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow and start/busy/done handshake.
module serial_subtractor8 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero,
   output logic             overflow
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_sr_q;
   logic [CntW-1:0]  cnt_q;
   logic             br_q;
   logic             a_msb_q;
   logic             b_msb_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic             zero_q;
   logic             overflow_q;

   logic             a0;
   logic             b0;
   logic             d_bit;
   logic             br_d;
   logic [WIDTH-1:0] diff_d;
   logic             last_bit;
   logic             accept;
   logic             overflow_d;

   // Full-subtractor cell and the difference word as it will look after this edge.
   always_comb begin
      a0         = a_q[0];
      b0         = b_q[0];
      d_bit      = a0 ^ b0 ^ br_q;
      br_d       = (~a0 & b0) | (~(a0 ^ b0) & br_q);
      diff_d     = {d_bit, diff_sr_q[WIDTH-1:1]};
      last_bit   = (cnt_q == LastBit);
      accept     = start & ~busy_q;
      overflow_d = (a_msb_q != b_msb_q) & (diff_d[WIDTH-1] != a_msb_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         diff_sr_q  <= '0;
         cnt_q      <= '0;
         br_q       <= 1'b0;
         a_msb_q    <= 1'b0;
         b_msb_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         diff_q     <= '0;
         borrow_q   <= 1'b0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
            end
            StRun: begin
               a_q       <= {1'b0, a_q[WIDTH-1:1]};
               b_q       <= {1'b0, b_q[WIDTH-1:1]};
               br_q      <= br_d;
               diff_sr_q <= diff_d;
               cnt_q     <= cnt_q + 1'b1;
               if (last_bit) begin
                  state_q    <= StDone;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  diff_q     <= diff_d;
                  borrow_q   <= br_d;
                  zero_q     <= (diff_d == '0);
                  overflow_q <= overflow_d;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
         // Accept overrides the IDLE/DONE branches; busy_q blocks it during RUN.
         if (accept) begin
            state_q <= StRun;
            a_q     <= a;
            b_q     <= b;
            br_q    <= borrow_in;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;
   assign zero       = zero_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor8.sv
// Self-checking bench for serial_subtractor8: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_serial_subtractor8;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         zero;
   logic         overflow;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   serial_subtractor8 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a_in),
      .b         (b_in),
      .borrow_in (bin),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .borrow_out(borrow_out),
      .zero      (zero),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bo;
      logic         z;
      logic         ov;
   } res_t;

   // Reference result from plain integer arithmetic.
   function automatic res_t predict(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic bi);
      res_t   r;
      longint ud;
      longint sd;
      ud     = longint'(a) - longint'(b) - longint'(bi);
      sd     = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
      r.diff = W'(ud);
      r.bo   = (ud < 0);
      r.z    = (r.diff == '0);
      r.ov   = (sd < -(longint'(1) << (W - 1))) || (sd > (longint'(1) << (W - 1)) - 1);
      return r;
   endfunction

   // Transaction-level model: an accepted start yields busy for W cycles, then one done cycle.
   logic m_busy = 1'b0;
   logic m_done = 1'b0;
   res_t m_res  = '0;
   res_t p_res  = '0;
   int   m_left = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_res  <= '0;
         m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_res  <= p_res;
            end
            m_left <= m_left - 1;
         end else if (start) begin
            m_busy <= 1'b1;
            m_left <= W;
            p_res  <= predict(a_in, b_in, bin);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_vec++;
         if ({busy, done, diff, borrow_out, zero, overflow} !==
             {m_busy, m_done, m_res.diff, m_res.bo, m_res.z, m_res.ov}) begin
            n_err++;
            $display("FAIL cycle_check t=%0t got busy=%b done=%b diff=%0d bo=%b z=%b ov=%b want busy=%b done=%b diff=%0d bo=%b z=%b ov=%b",
                     $time, busy, done, diff, borrow_out, zero, overflow,
                     m_busy, m_done, m_res.diff, m_res.bo, m_res.z, m_res.ov);
         end
      end
   end

   task automatic check(input string name, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
      end
   endtask

   task automatic check_res(input string name, input logic [W-1:0] ed, input logic eb,
                            input logic ez, input logic eo);
      check({name, "_diff"}, longint'(diff), longint'(ed));
      check({name, "_borrow"}, longint'(borrow_out), longint'(eb));
      check({name, "_zero"}, longint'(zero), longint'(ez));
      check({name, "_ovf"}, longint'(overflow), longint'(eo));
   endtask

   task automatic check_all_zero(input string name);
      check(name, longint'({busy, done, diff, borrow_out, zero, overflow}), 0);
   endtask

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      bin   = bi;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      bin   = 1'($urandom);
   endtask

   // Returns at the negedge inside the done cycle (or after the bound expires).
   task automatic wait_done(input string name, output int cyc, output int busy_n);
      cyc    = 0;
      busy_n = 0;
      while (!done && cyc < 40) begin
         if (busy) busy_n++;
         @(negedge clk);
         cyc++;
      end
      check({name, "_done_seen"}, longint'(done), 1);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bi;
      logic [W-1:0] d;
      logic         bo;
      logic         z;
      logic         ov;
   } vec_t;

   vec_t tbl[5] = '{
      '{a: 8'd10,  b: 8'd16,  bi: 1'b0, d: 8'd250, bo: 1'b1, z: 1'b0, ov: 1'b0},
      '{a: 8'd35,  b: 8'd35,  bi: 1'b0, d: 8'd0,   bo: 1'b0, z: 1'b1, ov: 1'b0},
      '{a: 8'h80,  b: 8'h01,  bi: 1'b0, d: 8'h7F,  bo: 1'b0, z: 1'b0, ov: 1'b1},
      '{a: 8'h7F,  b: 8'hFF,  bi: 1'b0, d: 8'h80,  bo: 1'b1, z: 1'b0, ov: 1'b1},
      '{a: 8'hFF,  b: 8'h7F,  bi: 1'b1, d: 8'h7F,  bo: 1'b0, z: 1'b0, ov: 1'b1}
   };

   initial begin
      int cyc;
      int busy_n;
      int done_n;
      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      bin   = 1'b0;
      #1;
      check_all_zero("reset_outputs");
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;

      launch(8'd62, 8'd35, 1'b0);
      wait_done("basic", cyc, busy_n);
      check("basic_busy_cycles", busy_n, 8);
      check_res("basic", 8'd27, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("basic_done_one_cycle", longint'(done), 0);

      foreach (tbl[i]) begin
         launch(tbl[i].a, tbl[i].b, tbl[i].bi);
         wait_done($sformatf("tbl%0d", i), cyc, busy_n);
         check_res($sformatf("tbl%0d", i), tbl[i].d, tbl[i].bo, tbl[i].z, tbl[i].ov);
      end

      launch(8'd0, 8'd0, 1'b1);
      wait_done("bin", cyc, busy_n);
      check_res("bin", 8'hFF, 1'b1, 1'b0, 1'b0);
      a_in  = 8'd5;
      b_in  = 8'd3;
      bin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("b2b_latency", cyc, 9);
      check_res("b2b", 8'd2, 1'b0, 1'b0, 1'b0);

      launch(8'd100, 8'd1, 1'b0);
      repeat (2) @(negedge clk);
      a_in  = 8'd7;
      b_in  = 8'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_in  = 8'd3;
      b_in  = 8'd200;
      wait_done("busy_start", cyc, busy_n);
      check_res("busy_start", 8'd99, 1'b0, 1'b0, 1'b0);

      launch(8'd9, 8'd4, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst    = 1'b0;
      done_n = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) done_n++;
      end
      check("no_done_after_reset", done_n, 0);
      check_all_zero("after_reset_idle");

      launch(8'd200, 8'd55, 1'b0);
      wait_done("post_reset", cyc, busy_n);
      check_res("post_reset", 8'd145, 1'b0, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t simulation did not complete", $time);
      $fatal(1);
   end

endmodule

// File: doc/serial_subtractor8.md
# serial_subtractor8

Bit-serial subtractor computing `a - b - borrow_in` one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a registered borrow. It is the inverse-direction companion of the team's ripple-carry adders. It trades latency for area in datapaths where one subtraction every `WIDTH+1` cycles is sufficient. A start/busy/done handshake fronts it; results are registered and held until the next completion.

## Interface

- `WIDTH`, 8: operand and result width in bits; legal range 2 to 32.

- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only while `busy`=0.
- `a`  input  WIDTH  minuend; captured on the accepting edge.
- `b`  input  WIDTH  subtrahend; captured on the accepting edge.
- `borrow_in`  input  1  initial borrow; captured on the accepting edge.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse: results valid and newly updated.
- `diff`  output  WIDTH  `(a - b - borrow_in) mod 2^WIDTH`.
- `borrow_out`  output  1  unsigned borrow: 1 iff `a < b + borrow_in`.
- `zero`  output  1  `diff == 0`.
- `overflow`  output  1  two's-complement overflow.

## Operation

- The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE**
  - `start`=1 captures `a`, `b` and `borrow_in` into shift registers and the borrow flop.
  - The bit counter is cleared and the FSM moves to RUN.
  - `start`=0: stay in IDLE.
- **RUN**, one bit per edge:
  - Difference bit: `d = a0 ^ b0 ^ br`.
  - Next borrow: `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - The `a` and `b` shift registers shift right. `d` enters the MSB of the difference shift register.
  - On the edge that processes bit `WIDTH-1`, the FSM moves to DONE and the output registers load:
    - `diff` from the completed difference.
    - `borrow_out` from the final borrow.
    - `zero` = `(diff == 0)`.
    - `overflow` = `(a[MSB] != b[MSB]) & (diff[MSB] != a[MSB])`, using the captured operands.
- **DONE**
  - `done`=1 for this single cycle, and the FSM returns to IDLE on the next edge.
  - `busy`=0 in DONE, so `start` in this cycle is accepted (FSM goes DONE -> RUN). This gives back-to-back operations.
- `start` while `busy`=1 is ignored; there is no queuing. Changes on `a`, `b` or `borrow_in` after capture have no effect.
- Result outputs are not cleared on `start`. They hold the previous result until the next completion.
- `borrow_out`, `zero` and `overflow` always refer to the same operation as `diff`.

## Timing

- All outputs reset to 0 while `rst`=1: `busy`, `done`, `diff`, `borrow_out`, `zero` and `overflow`. The FSM is forced to IDLE and the counter cleared.
- Reset takes effect asynchronously on assertion. Deassertion is synchronous to `clk` by system convention.
- Reset during RUN aborts the operation: no `done` pulse follows, and results read 0.
- Let E0 be the edge that samples `start`=1 with `busy`=0:
  - `busy` is high from after E0 until after E_WIDTH, i.e. `WIDTH` cycles.
  - Results update at E_WIDTH, and `done` is high for the cycle between E_WIDTH and E_WIDTH+1.
  - Latency from accepting edge to results valid: `WIDTH` cycles.
  - Sustained throughput: one operation per `WIDTH+1` cycles.
- A start accepted at E_WIDTH+1 (during `done`) produces its `done` after E_(2·WIDTH+1).
- `busy` and `done` are never high in the same cycle.
- `busy` and `done` are registered outputs with no combinational input-to-output paths.

## Test plan

1. Reset, then `a`=62, `b`=35, `borrow_in`=0, 1-cycle `start`. Expect `busy` high for 8 cycles, then a single `done` pulse with `diff`=27, `borrow_out`=0, `zero`=0, `overflow`=0.
2. Wraparound and flags:
   - `a`=10, `b`=16: `diff`=250, `borrow_out`=1, `overflow`=0.
   - `a`=35, `b`=35: `diff`=0, `zero`=1, `borrow_out`=0.
3. Signed overflow:
   - `a`=0x80, `b`=0x01: `diff`=0x7F, `overflow`=1, `borrow_out`=0.
   - `a`=0x7F, `b`=0xFF: `diff`=0x80, `overflow`=1, `borrow_out`=1.
4. Borrow-in: `a`=0, `b`=0, `borrow_in`=1 gives `diff`=0xFF and `borrow_out`=1. Back-to-back, `start` during that `done` cycle with `a`=5, `b`=3 gives `diff`=2 exactly 9 cycles after the first `done`.
5. Start while busy: start `a`=100, `b`=1, then pulse `start` with `a`=7, `b`=7 at cycle 3. The pulse is ignored and `diff`=99. Operand inputs changed mid-RUN also have no effect.
6. Reset mid-op: assert `rst` at cycle 4 of RUN. All outputs must be 0 immediately with no clock edge, and no `done` pulse follows. A subsequent operation with `a`=200, `b`=55 gives `diff`=145.
